// File: rtl/mask_pkg.sv
// Shared types and helpers for the M-ary ASK PWM modulator.
// Holds the FSM state type, derived-size helpers and the Gray decoder.
// Symbol widths up to 3 bits are supported by the Gray decoder.
package mask_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int MAX_BPS = 3;

  // Number of amplitude levels for a given symbol width.
  function automatic int n_lvl(input int bps);
    return 1 << bps;
  endfunction

  // Number of symbols that make up one sample.
  function automatic int n_sym(input int sample_w, input int bps);
    return sample_w / bps;
  endfunction

  // PWM threshold width: one bit wider than the PWM counter so the top level fits.
  function automatic int thr_w(input int pwm_w);
    return pwm_w + 1;
  endfunction

  // Gray code to binary; narrower symbols are zero-extended, which decodes unchanged.
  function automatic logic [MAX_BPS-1:0] gray2bin(input logic [MAX_BPS-1:0] g);
    logic [MAX_BPS-1:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/mask_pwm_level.sv
// Carrier gating, PWM compare and one-hot level decode for one symbol stream.
// Outputs are registered from the next-cycle level/run inputs, so they line up with the FSM.
// Counters restart whenever sym_start_i is set; everything clears while run_i is low.
module mask_pwm_level
  import mask_pkg::*;
#(
  parameter int BPS         = 2,
  parameter int CARRIER_DIV = 8,
  parameter int PWM_W       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    run_i,
  input  logic                    sym_start_i,
  input  logic [BPS-1:0]          level_i,
  output logic                    ask_o,
  output logic [n_lvl(BPS)-1:0]   level_onehot_o
);

  localparam int N_LVL = n_lvl(BPS);
  localparam int THR_W = thr_w(PWM_W);
  localparam int CW    = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(CARRIER_DIV - 1);

  logic [CW-1:0]    carrier_cnt_q, carrier_cnt_d;
  logic             phase_q, phase_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             ask_q, ask_d;
  logic [N_LVL-1:0] onehot_q, onehot_d;
  logic [THR_W-1:0] thr;

  // Advance carrier/PWM position for the next cycle and derive its outputs.
  always_comb begin
    thr           = (THR_W'(level_i) + THR_W'(1)) << (PWM_W - BPS);
    carrier_cnt_d = carrier_cnt_q;
    phase_d       = phase_q;
    pwm_cnt_d     = pwm_cnt_q;
    if (sym_start_i) begin
      carrier_cnt_d = '0;
      phase_d       = 1'b1;
      pwm_cnt_d     = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      if (carrier_cnt_q == LAST_C) begin
        carrier_cnt_d = '0;
        phase_d       = ~phase_q;
      end else begin
        carrier_cnt_d = carrier_cnt_q + CW'(1);
      end
    end
    ask_d    = phase_d & ({1'b0, pwm_cnt_d} < thr);
    onehot_d = N_LVL'(1) << level_i;
    if (!run_i) begin
      carrier_cnt_d = '0;
      phase_d       = 1'b0;
      pwm_cnt_d     = '0;
      ask_d         = 1'b0;
      onehot_d      = '0;
    end
  end

  // Register counters and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carrier_cnt_q <= '0;
      phase_q       <= 1'b0;
      pwm_cnt_q     <= '0;
      ask_q         <= 1'b0;
      onehot_q      <= '0;
    end else begin
      carrier_cnt_q <= carrier_cnt_d;
      phase_q       <= phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      ask_q         <= ask_d;
      onehot_q      <= onehot_d;
    end
  end

  assign ask_o          = ask_q;
  assign level_onehot_o = onehot_q;

endmodule

// File: rtl/mask_pwm_modulator.sv
// M-ary ASK modulator: serialises samples MSB-first into BPS-bit symbols as gated PWM.
// First symbol appears the cycle after the handshake; frame = N_SYM*SYM_DIV cycles.
// in_ready is high only when idle or on the last frame cycle, allowing gapless chaining.
module mask_pwm_modulator
  import mask_pkg::*;
#(
  parameter int SAMPLE_W    = 8,
  parameter int BPS         = 2,
  parameter int GRAY        = 0,
  parameter int SYM_DIV     = 32,
  parameter int CARRIER_DIV = 8,
  parameter int PWM_W       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  input  logic [SAMPLE_W-1:0]     in_data_i,
  output logic                    in_ready_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    ask_out_o,
  output logic [n_lvl(BPS)-1:0]   level_onehot_o
);

  localparam int N_SYM = n_sym(SAMPLE_W, BPS);
  localparam int SI_W  = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int DIV_W = $clog2(SYM_DIV);
  localparam logic [SI_W-1:0]  LAST_SYM = SI_W'(N_SYM - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SYM_DIV - 1);

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SI_W-1:0]     sym_idx_q, sym_idx_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                in_ready_q, busy_q, frame_done_q;
  logic                fire, last_q, last_d, sym_start;
  logic [BPS-1:0]      sym_bits, level;

  assign fire   = in_valid_i & in_ready_q;
  assign last_q = (state_q == SEND) && (sym_idx_q == LAST_SYM) && (div_cnt_q == LAST_DIV);

  // Next-state: load on handshake, otherwise step through symbols and return to idle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    sym_idx_d = sym_idx_q;
    div_cnt_d = div_cnt_q;
    sym_start = 1'b0;
    if (fire) begin
      state_d   = SEND;
      shift_d   = in_data_i;
      sym_idx_d = '0;
      div_cnt_d = '0;
      sym_start = 1'b1;
    end else if (state_q == SEND) begin
      if (last_q) begin
        state_d   = IDLE;
        shift_d   = '0;
        sym_idx_d = '0;
        div_cnt_d = '0;
      end else if (div_cnt_q == LAST_DIV) begin
        div_cnt_d = '0;
        sym_idx_d = sym_idx_q + SI_W'(1);
        shift_d   = shift_q << BPS;
        sym_start = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign last_d   = (state_d == SEND) && (sym_idx_d == LAST_SYM) && (div_cnt_d == LAST_DIV);
  assign sym_bits = shift_d[SAMPLE_W-1 -: BPS];
  assign level    = (GRAY != 0) ? BPS'(gray2bin(MAX_BPS'(sym_bits))) : sym_bits;

  // FSM state and registered handshake/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      sym_idx_q    <= '0;
      div_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      sym_idx_q    <= sym_idx_d;
      div_cnt_q    <= div_cnt_d;
      in_ready_q   <= (state_d == IDLE) | last_d;
      busy_q       <= (state_d == SEND);
      frame_done_q <= last_d;
    end
  end

  mask_pwm_level #(
    .BPS         (BPS),
    .CARRIER_DIV (CARRIER_DIV),
    .PWM_W       (PWM_W)
  ) u_level (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .run_i          (state_d == SEND),
    .sym_start_i    (sym_start),
    .level_i        (level),
    .ask_o          (ask_out_o),
    .level_onehot_o (level_onehot_o)
  );

  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_mask_pwm_modulator.sv
// Bench for mask_pwm_modulator: binary, Gray and 1-bit-per-symbol instances.
// Expected waveforms come from a per-cycle arithmetic model of the frame.
// Covers reset, fixed and random frames, gapless chaining and mid-frame reset.
module tb_mask_pwm_modulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       r0, r1, r2, b0, b1, b2, f0, f1, f2, a0, a1, a2;
  logic [3:0] oh0, oh1;
  logic [1:0] oh2;

  int checks = 0;
  int errors = 0;

  mask_pwm_modulator #(.GRAY(0)) u0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .in_data_i(d0), .in_ready_o(r0),
    .busy_o(b0), .frame_done_o(f0), .ask_out_o(a0), .level_onehot_o(oh0));
  mask_pwm_modulator #(.GRAY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_data_i(d1), .in_ready_o(r1),
    .busy_o(b1), .frame_done_o(f1), .ask_out_o(a1), .level_onehot_o(oh1));
  mask_pwm_modulator #(.BPS(1)) u2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v2), .in_data_i(d2), .in_ready_o(r2),
    .busy_o(b2), .frame_done_o(f2), .ask_out_o(a2), .level_onehot_o(oh2));

  // Read the outputs of one instance.
  task automatic get_obs(input int dut, output logic rdy, output logic bsy, output logic fd,
                         output logic ask, output logic [3:0] oh);
    case (dut)
      0:       begin rdy = r0; bsy = b0; fd = f0; ask = a0; oh = oh0; end
      1:       begin rdy = r1; bsy = b1; fd = f1; ask = a1; oh = oh1; end
      default: begin rdy = r2; bsy = b2; fd = f2; ask = a2; oh = {2'b00, oh2}; end
    endcase
  endtask

  task automatic drive(input int dut, input logic vv, input logic [7:0] dd);
    case (dut)
      0:       begin v0 = vv; d0 = dd; end
      1:       begin v1 = vv; d1 = dd; end
      default: begin v2 = vv; d2 = dd; end
    endcase
  endtask

  // Expected level and ask_out for cycle t of a frame (SAMPLE_W=8, SYM_DIV=32, CARRIER_DIV=8, PWM_W=2).
  function automatic void model(input int bps, input int gray, input int sample, input int t,
                                output int lvl, output logic ask);
    int sym, k, bits;
    sym  = t / 32;
    k    = t % 32;
    bits = (sample >> (8 - bps * (sym + 1))) & ((1 << bps) - 1);
    lvl  = (gray != 0) ? (bits ^ (bits >> 1) ^ (bits >> 2)) : bits;
    ask  = (((k / 8) % 2) == 0) && ((k % 4) < ((lvl + 1) << (2 - bps)));
  endfunction

  task automatic test_reset();
    logic rdy, bsy, fd, ask;
    logic [3:0] oh;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, rdy, bsy, fd, ask, oh);
      checks++;
      if ({rdy, bsy, fd, ask, oh} !== 8'h00) begin
        errors++;
        $display("FAIL reset_state dut%0d got rdy/busy/fd/ask/oh=%b exp 00000000", i, {rdy, bsy, fd, ask, oh});
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, rdy, bsy, fd, ask, oh);
      checks++;
      if ({rdy, bsy, fd, ask, oh} !== 8'h80) begin
        errors++;
        $display("FAIL reset_release dut%0d got rdy/busy/fd/ask/oh=%b exp 10000000", i, {rdy, bsy, fd, ask, oh});
      end
    end
  endtask

  // One full frame on an idle instance; noisy toggles in_valid/in_data while busy.
  task automatic test_frame(input int dut, input int bps, input int gray, input logic [7:0] sample,
                            input string name, input bit noisy);
    logic rdy, bsy, fd, ask, eask;
    logic [3:0] oh, eoh;
    int lvl, flen;
    flen = (8 / bps) * 32;
    get_obs(dut, rdy, bsy, fd, ask, oh);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready got %b exp 1", name, rdy);
    end
    drive(dut, 1'b1, sample);
    @(posedge clk);
    #1;
    for (int t = 0; t < flen; t++) begin
      get_obs(dut, rdy, bsy, fd, ask, oh);
      model(bps, gray, sample, t, lvl, eask);
      eoh = 4'(1 << lvl);
      checks++;
      if (oh !== eoh) begin
        errors++;
        $display("FAIL %s onehot t=%0d got %b exp %b", name, t, oh, eoh);
      end
      checks++;
      if (ask !== eask) begin
        errors++;
        $display("FAIL %s ask_out t=%0d got %b exp %b", name, t, ask, eask);
      end
      checks++;
      if ({bsy, fd, rdy} !== {1'b1, (t == flen - 1), (t == flen - 1)}) begin
        errors++;
        $display("FAIL %s busy/done/ready t=%0d got %b exp %b", name, t, {bsy, fd, rdy},
                 {1'b1, (t == flen - 1), (t == flen - 1)});
      end
      if (noisy && t < flen - 1) drive(dut, 1'($urandom % 2), 8'($urandom));
      else drive(dut, 1'b0, 8'($urandom));
      @(posedge clk);
      #1;
    end
    get_obs(dut, rdy, bsy, fd, ask, oh);
    checks++;
    if ({rdy, bsy, fd, ask, oh} !== 8'h80) begin
      errors++;
      $display("FAIL %s after_frame got rdy/busy/fd/ask/oh=%b exp 10000000", name, {rdy, bsy, fd, ask, oh});
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, bsy, fd, ask, eask;
    logic [3:0] oh;
    int lvl;
    logic [7:0] smp [2];
    smp[0] = 8'hFF;
    smp[1] = 8'h00;
    drive(0, 1'b1, smp[0]);
    @(posedge clk);
    #1;
    for (int f = 0; f < 2; f++) begin
      for (int t = 0; t < 128; t++) begin
        get_obs(0, rdy, bsy, fd, ask, oh);
        model(2, 0, smp[f], t, lvl, eask);
        checks++;
        if ({oh, ask, bsy, fd, rdy} !== {4'(1 << lvl), eask, 1'b1, (t == 127), (t == 127)}) begin
          errors++;
          $display("FAIL b2b frame%0d t=%0d got oh/ask/busy/done/ready=%b exp %b", f, t,
                   {oh, ask, bsy, fd, rdy}, {4'(1 << lvl), eask, 1'b1, (t == 127), (t == 127)});
        end
        if (t == 127) drive(0, (f == 0), smp[1]);
        @(posedge clk);
        #1;
      end
    end
    get_obs(0, rdy, bsy, fd, ask, oh);
    checks++;
    if ({rdy, bsy, fd, ask, oh} !== 8'h80) begin
      errors++;
      $display("FAIL b2b after got rdy/busy/fd/ask/oh=%b exp 10000000", {rdy, bsy, fd, ask, oh});
    end
  endtask

  task automatic test_mid_reset();
    logic rdy, bsy, fd, ask;
    logic [3:0] oh;
    drive(0, 1'b1, 8'($urandom));
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    get_obs(0, rdy, bsy, fd, ask, oh);
    checks++;
    if ({rdy, bsy, fd, ask, oh} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got rdy/busy/fd/ask/oh=%b exp 00000000", {rdy, bsy, fd, ask, oh});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    get_obs(0, rdy, bsy, fd, ask, oh);
    checks++;
    if ({rdy, bsy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_release got rdy/busy=%b exp 10", {rdy, bsy});
    end
    for (int t = 0; t < 120; t++) begin
      @(posedge clk);
      #1;
      get_obs(0, rdy, bsy, fd, ask, oh);
      checks++;
      if ({fd, bsy, ask} !== 3'b000) begin
        errors++;
        $display("FAIL mid_reset_no_done t=%0d got done/busy/ask=%b exp 000", t, {fd, bsy, ask});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      test_frame(0, 2, 0, 8'($urandom), "rand_bin", 1'b1);
      test_frame(1, 2, 1, 8'($urandom), "rand_gray", 1'b1);
      test_frame(2, 1, 0, 8'($urandom), "rand_bps1", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 2, 0, 8'hB4, "bin_B4", 1'b0);
    test_frame(1, 2, 1, 8'hB4, "gray_B4", 1'b0);
    test_frame(2, 1, 0, 8'hA5, "bps1_A5", 1'b0);
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
